load_store_unit: RTL and testbench

- Sits between the single-cycle core's ALU/control outputs and a handshaked data memory. Replaces the core's direct combinational memory access path.
- Converts the core's load/store request into a word-aligned memory transaction with byte enables.
- Extracts and extends load data; stalls the core until the access completes.
- Flags misaligned, illegal and timed-out accesses.

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// Load/store unit: turns a core load/store request into a handshaked, word-aligned
// memory access with byte enables, and returns extended load data with an error flag.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_illegal;
  logic              w_misaligned;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load_data;
  logic              w_capture;
  logic              w_upd_result;
  logic [31:0]       w_rdata_nxt;
  logic              w_err_nxt;

  // Request decode on the raw core inputs, used only when accepting in IDLE
  always_comb begin
    w_illegal    = lsu_we ? (lsu_funct3 > 3'b010)
                          : (lsu_funct3 == 3'b011 || lsu_funct3[2:1] == 2'b11);
    w_misaligned = (lsu_funct3[1:0] == 2'b01 && lsu_addr[0]) ||
                   (lsu_funct3[1:0] == 2'b10 && lsu_addr[1:0] != 2'b00);
    case (lsu_funct3[1:0])
      2'b00:   begin w_be = 4'b0001 << lsu_addr[1:0]; w_wdata = {4{lsu_wdata[7:0]}};  end
      2'b01:   begin w_be = 4'b0011 << lsu_addr[1:0]; w_wdata = {2{lsu_wdata[15:0]}}; end
      default: begin w_be = 4'b1111;                  w_wdata = lsu_wdata;            end
    endcase
  end

  // Lane selection and extension of the returned read word
  always_comb begin
    w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_capture    = 1'b0;
    w_upd_result = 1'b0;
    w_rdata_nxt  = '0;
    w_err_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lsu_valid) begin
          w_capture = 1'b1;
          w_cnt_nxt = '0;
          if (w_illegal || w_misaligned) begin
            w_state_nxt  = S_DONE;
            w_upd_result = 1'b1;
            w_err_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (mem_gnt) begin
          w_state_nxt = S_WAIT;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = S_DONE;
          w_upd_result = 1'b1;
          w_err_nxt    = 1'b1;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (mem_rvalid) begin
          w_state_nxt  = S_DONE;
          w_upd_result = 1'b1;
          w_rdata_nxt  = r_we ? 32'd0 : w_load_data;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = S_DONE;
          w_upd_result = 1'b1;
          w_err_nxt    = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Captured request and held result; result only changes on entry to DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_we        <= lsu_we;
        r_funct3    <= lsu_funct3;
        r_off       <= lsu_addr[1:0];
        r_mem_addr  <= {lsu_addr[31:2], 2'b00};
        r_mem_wdata <= w_wdata;
        r_mem_be    <= w_be;
      end
      if (w_upd_result) begin
        r_rdata <= w_rdata_nxt;
        r_err   <= w_err_nxt;
      end
    end
  end

  assign mem_req   = (r_state == S_REQ);
  assign lsu_done  = (r_state == S_DONE);
  assign lsu_stall = lsu_valid & ~lsu_done;
  assign mem_we    = r_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign lsu_rdata = r_rdata;
  assign lsu_err   = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Directed bench for load_store_unit: scripted memory responses, hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_valid;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_stall;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .lsu_valid  (lsu_valid),
    .lsu_we     (lsu_we),
    .lsu_funct3 (lsu_funct3),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_stall  (lsu_stall),
    .lsu_done   (lsu_done),
    .lsu_rdata  (lsu_rdata),
    .lsu_err    (lsu_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One request; memory grants after gnt_dly REQ cycles, answers rvalid in the first WAIT cycle
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int gnt_dly, input logic [31:0] rd,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int exp_nreq);
    int   nreq;
    int   lat;
    logic granted;
    logic done_seen;
    logic [31:0] got_rdata;
    logic        got_err;
    nreq = 0; lat = 0; granted = 1'b0; done_seen = 1'b0;
    got_rdata = '0; got_err = 1'b0;
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
    #1 check({tag, "_stall0"}, 32'(lsu_stall), 32'd1);
    for (int c = 1; c <= 40 && !done_seen; c++) begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (lsu_done) begin
        done_seen = 1'b1;
        lat       = c;
        got_rdata = lsu_rdata;
        got_err   = lsu_err;
        check({tag, "_stall_done"}, 32'(lsu_stall), 32'd0);
      end else begin
        check({tag, "_stall"}, 32'(lsu_stall), 32'd1);
        if (mem_req) begin
          nreq++;
          check({tag, "_addr"}, mem_addr, exp_addr);
          check({tag, "_be"}, 32'(mem_be), 32'(exp_be));
          check({tag, "_wdata"}, mem_wdata, exp_wdata);
          check({tag, "_we"}, 32'(mem_we), 32'(we));
          if (nreq > gnt_dly) begin
            mem_gnt = 1'b1;
            granted = 1'b1;
          end
        end else if (granted) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd;
        end
      end
    end
    lsu_valid = 1'b0;
    if (!done_seen) check({tag, "_no_done"}, 32'd0, 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_nreq"}, 32'(nreq), 32'(exp_nreq));
    check({tag, "_rdata"}, got_rdata, exp_rdata);
    check({tag, "_err"}, 32'(got_err), 32'(exp_err));
  endtask

  initial begin
    reset = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = '0; lsu_addr = '0;
    lsu_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_done", 32'(lsu_done), 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);
    check("rst_err", 32'(lsu_err), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    reset = 1'b0;

    //     tag     we    f3      addr   wdata         dly rd            addr   be       wdata         rdata         err lat nreq
    access("lw",   1'b0, 3'b010, 32'h10, 32'h0,        0, 32'hDEADBEEF, 32'h10, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1);
    access("lb",   1'b0, 3'b000, 32'h13, 32'h0,        0, 32'h80FF0000, 32'h10, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1);
    access("lbu",  1'b0, 3'b100, 32'h13, 32'h0,        0, 32'h80FF0000, 32'h10, 4'b1000, 32'h0,        32'h00000080, 1'b0, 3, 1);
    access("lhu",  1'b0, 3'b101, 32'h12, 32'h0,        0, 32'h80FF0000, 32'h10, 4'b1100, 32'h0,        32'h000080FF, 1'b0, 3, 1);
    access("lh",   1'b0, 3'b001, 32'h12, 32'h0,        0, 32'h80FF0000, 32'h10, 4'b1100, 32'h0,        32'hFFFF80FF, 1'b0, 3, 1);
    access("lb0",  1'b0, 3'b000, 32'h14, 32'h0,        0, 32'h1234567F, 32'h14, 4'b0001, 32'h0,        32'h0000007F, 1'b0, 3, 1);
    access("sh",   1'b1, 3'b001, 32'h22, 32'h1234ABCD, 4, 32'hFFFFFFFF, 32'h20, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0, 7, 5);
    access("sb",   1'b1, 3'b000, 32'h21, 32'hCAFE0077, 0, 32'hFFFFFFFF, 32'h20, 4'b0010, 32'h77777777, 32'h0,        1'b0, 3, 1);
    access("sw",   1'b1, 3'b010, 32'h2C, 32'hA5A55A5A, 1, 32'h0,        32'h2C, 4'b1111, 32'hA5A55A5A, 32'h0,        1'b0, 4, 2);
    access("lw_mis", 1'b0, 3'b010, 32'h6, 32'h0,       0, 32'h0,        32'h0,  4'b0000, 32'h0,        32'h0,        1'b1, 1, 0);
    access("lw_ok2", 1'b0, 3'b010, 32'h8, 32'h0,       0, 32'h11223344, 32'h8,  4'b1111, 32'h0,        32'h11223344, 1'b0, 3, 1);
    access("sh_mis", 1'b1, 3'b001, 32'h5, 32'h0,       0, 32'h0,        32'h0,  4'b0000, 32'h0,        32'h0,        1'b1, 1, 0);
    access("ld_ill", 1'b0, 3'b011, 32'h10, 32'h0,      0, 32'h0,        32'h0,  4'b0000, 32'h0,        32'h0,        1'b1, 1, 0);
    access("st_ill", 1'b1, 3'b100, 32'h10, 32'h0,      0, 32'h0,        32'h0,  4'b0000, 32'h0,        32'h0,        1'b1, 1, 0);
    access("tmo",  1'b0, 3'b010, 32'h30, 32'h0,     1000, 32'h0,        32'h30, 4'b1111, 32'h0,        32'h0,        1'b1, 9, 8);

    // Late rvalid after the timeout must not complete anything
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    check("late_rv_done", 32'(lsu_done), 32'd0);
    check("late_rv_req", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("late_rv_done2", 32'(lsu_done), 32'd0);

    // Load with nonzero result so the reset clearing of rdata is observable
    access("lw_pre", 1'b0, 3'b010, 32'h40, 32'h0,      0, 32'hCAFEF00D, 32'h40, 4'b1111, 32'h0,        32'hCAFEF00D, 1'b0, 3, 1);

    // Reset asserted while waiting for read data
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h44;
    @(negedge clk);
    check("rw_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rw_in_wait", 32'(mem_req), 32'd0);
    check("rw_pre_rdata", lsu_rdata, 32'hCAFEF00D);
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
    #1;
    check("rw_req0", 32'(mem_req), 32'd0);
    check("rw_done0", 32'(lsu_done), 32'd0);
    check("rw_rdata0", lsu_rdata, 32'd0);
    check("rw_err0", 32'(lsu_err), 32'd0);
    @(negedge clk);
    lsu_valid = 1'b0;
    reset = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    check("rw_post_done", 32'(lsu_done), 32'd0);
    check("rw_post_req", 32'(mem_req), 32'd0);
    check("rw_post_rdata", lsu_rdata, 32'd0);
    access("lw_fresh", 1'b0, 3'b010, 32'h48, 32'h0,    0, 32'h0BADCAFE, 32'h48, 4'b1111, 32'h0,        32'h0BADCAFE, 1'b0, 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
